tw_slave_regif: RTL
===================

# tw_slave_regif

Synthesizable three-wire bus slave (responder) for the three-wire master's protocol. It oversamples the bus clock, chip-select and data line in the system clock domain and decodes each frame into a register-side write or read request. On read frames it drives the shared data line. It replaces the behavioural slave model in on-chip loopback and in FPGA builds that expose a register bank over the three-wire link.

## Interface
Parameters:
- ADDR_BITS, 9, address field width.
- DATA_BITS, 16, data field width.

Ports:
- in_clk  input  1  system clock; every flop is on its rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_tw_clock  input  1  three-wire bus clock; asynchronous to in_clk.
- in_tw_cs  input  1  chip-select, active low; asynchronous.
- io_tw_data  inout  1  shared serial data line; high-Z unless driving.
- out_addr  output  ADDR_BITS  captured address; held until the next frame's address completes.
- out_wr_data  output  DATA_BITS  captured write data; held until the next write completes.
- out_wr_strobe  output  1  one-cycle pulse. out_addr and out_wr_data are valid on it.
- out_rd_strobe  output  1  one-cycle pulse. out_addr is valid; read data is requested.
- in_rd_data  input  DATA_BITS  read data from the register bank.
- out_busy  output  1  high while a frame is being decoded.
- out_frame_err  output  1  one-cycle pulse when a frame is aborted.

## Operation
- Input sampling:
  - in_tw_clock, in_tw_cs and io_tw_data each pass through a 2-flop synchronizer.
  - A third register on the clock path detects rising edges. Data is sampled from the synchronized value in the same cycle the edge is detected.
- Frame format, MSB first, counted in bus-clock rising edges while CS is low:
  - edge 1: command bit. 1 = write (master→slave), 0 = read.
  - edges 2..1+ADDR_BITS: address.
  - edges 2+ADDR_BITS..1+ADDR_BITS+DATA_BITS: data.
- Bit counter: 6 bits, counts edges within a frame and saturates. Edges beyond the last data bit are ignored until CS rises.
- FSM states: WAIT_HIGH, IDLE, CMD, ADDR, WDATA, RDATA, DONE.
  - WAIT_HIGH → IDLE when synchronized CS = 1.
  - IDLE → CMD when CS = 0.
  - CMD → ADDR on edge 1.
  - ADDR → WDATA or RDATA on the last address edge, per the command bit.
  - WDATA → DONE on the last data edge.
  - RDATA → DONE on the edge after the last data bit is driven.
  - DONE → IDLE when CS = 1.
- Abort: CS = 1 in CMD, ADDR, WDATA or RDATA.
  - Pulse out_frame_err, release the bus and go to IDLE.
  - No strobe is issued for the aborted frame; out_addr and out_wr_data keep their old values.
- Write:
  - out_wr_data updates on the last data edge.
  - out_wr_strobe pulses the following cycle.
- Read:
  - out_rd_strobe pulses the cycle after the last address edge.
  - in_rd_data is loaded into the shift register on the next edge (edge 2+ADDR_BITS). The MSB is driven that same cycle, with output enable high.
  - Each following edge shifts out the next bit.
  - Output enable drops on edge 2+ADDR_BITS+DATA_BITS, or immediately when CS goes high.
- out_busy is high in CMD, ADDR, WDATA and RDATA.

## Timing
- Reset values:
  - out_addr = 0, out_wr_data = 0.
  - out_wr_strobe = 0, out_rd_strobe = 0, out_busy = 0, out_frame_err = 0.
  - io_tw_data = high-Z; FSM = WAIT_HIGH.
- A reset during a frame takes effect on the next cycle: bus released, frame discarded, and nothing is decoded until CS has been seen high.
- Bus clock requirements: each phase (high and low) must last at least 4 in_clk cycles. CS setup before the first edge must be at least 4 in_clk cycles.
- Detection latency: 3 in_clk cycles from a pin edge to edge-detect.
- io_tw_data changes at most 4 in_clk cycles after the bus-clock rising edge. The master samples read data on the bus-clock falling edge.
- Register-bank contract: in_rd_data must be valid within 1 bus-clock period minus 5 in_clk cycles after out_rd_strobe, and held until the load.
- Back-to-back frames: a new frame is accepted as soon as CS high has been synchronized, with no extra gap.

## Test plan
- Write frame, cmd 1, addr 0x1B2, data 0xA4F9 → one out_wr_strobe with out_addr = 0x1B2, out_wr_data = 0xA4F9; io_tw_data never driven.
- Read frame, addr 0x155, in_rd_data = 0x96CA → out_rd_strobe with out_addr = 0x155; master samples 0x96CA on falling edges; bus high-Z after edge 27.
- Write aborted (CS high after 5 data bits) → out_frame_err pulse, no wr_strobe, out_wr_data unchanged; the following write of 0x0001 to 0x003 succeeds.
- in_rst asserted during read data bit 8 → next cycle io_tw_data high-Z and FSM in WAIT_HIGH; no decode until CS rises; the next read of 0x155 is correct.
- Read immediately followed by write with a minimum CS-high gap, plus 3 extra bus clocks after the write → both decoded, exactly one strobe each, extra clocks ignored.

Source files
------------

// File: rtl/tw_slave_regif.sv
// ============================================================================
// tw_slave_regif : three-wire bus responder decoding frames into reg requests
// Rev 1.0
// ============================================================================
`default_nettype none

module tw_slave_regif #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  wire                  io_tw_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_wr_data,
  output logic                 out_wr_strobe,
  output logic                 out_rd_strobe,
  input  logic [DATA_BITS-1:0] in_rd_data,
  output logic                 out_busy,
  output logic                 out_frame_err
);

  // Counter values seen on entry to the edge that ends each field.
  localparam logic [5:0] LAST_ADDR_CNT = 6'(ADDR_BITS);
  localparam logic [5:0] LAST_WR_CNT   = 6'(ADDR_BITS + DATA_BITS);
  localparam logic [5:0] RD_LOAD_CNT   = 6'(ADDR_BITS + 1);
  localparam logic [5:0] RD_END_CNT    = 6'(ADDR_BITS + DATA_BITS + 1);

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    CMD       = 3'd2,
    ADDR      = 3'd3,
    WDATA     = 3'd4,
    RDATA     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                 state;
  logic                   clk_s1, clk_s2, clk_s3;
  logic                   cs_s1, cs_s2;
  logic                   dat_s1, dat_s2;
  logic [5:0]             cnt;
  logic                   is_write;
  logic [ADDR_BITS-1:0]   addr_sh;
  logic [DATA_BITS-1:0]   data_sh;
  logic                   oe;
  logic                   tw_edge;
  logic [ADDR_BITS-1:0]   addr_next;
  logic [DATA_BITS-1:0]   data_next;

  assign tw_edge   = clk_s2 & ~clk_s3;
  assign addr_next = {addr_sh[ADDR_BITS-2:0], dat_s2};
  assign data_next = {data_sh[DATA_BITS-2:0], dat_s2};

  assign io_tw_data = oe ? data_sh[DATA_BITS-1] : 1'bz;
  assign out_busy   = (state == CMD) || (state == ADDR) ||
                      (state == WDATA) || (state == RDATA);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      clk_s1        <= 1'b0;
      clk_s2        <= 1'b0;
      clk_s3        <= 1'b0;
      cs_s1         <= 1'b0;
      cs_s2         <= 1'b0;
      dat_s1        <= 1'b0;
      dat_s2        <= 1'b0;
      state         <= WAIT_HIGH;
      cnt           <= '0;
      is_write      <= 1'b0;
      addr_sh       <= '0;
      data_sh       <= '0;
      oe            <= 1'b0;
      out_addr      <= '0;
      out_wr_data   <= '0;
      out_wr_strobe <= 1'b0;
      out_rd_strobe <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      clk_s1        <= in_tw_clock;
      clk_s2        <= clk_s1;
      clk_s3        <= clk_s2;
      cs_s1         <= in_tw_cs;
      cs_s2         <= cs_s1;
      dat_s1        <= io_tw_data;
      dat_s2        <= dat_s1;
      out_wr_strobe <= 1'b0;
      out_rd_strobe <= 1'b0;
      out_frame_err <= 1'b0;

      if (tw_edge && (cnt != 6'h3F) && (state != WAIT_HIGH) && (state != IDLE))
        cnt <= cnt + 6'd1;

      case (state)
        WAIT_HIGH: begin
          if (cs_s2) state <= IDLE;
        end

        IDLE: begin
          cnt <= '0;
          oe  <= 1'b0;
          if (!cs_s2) state <= CMD;
        end

        CMD, ADDR, WDATA, RDATA: begin
          if (cs_s2) begin
            // CS released mid-frame: abandon without touching the outputs.
            out_frame_err <= 1'b1;
            oe            <= 1'b0;
            state         <= IDLE;
          end else if (tw_edge) begin
            case (state)
              CMD: begin
                is_write <= dat_s2;
                addr_sh  <= '0;
                state    <= ADDR;
              end
              ADDR: begin
                addr_sh <= addr_next;
                if (cnt == LAST_ADDR_CNT) begin
                  out_addr <= addr_next;
                  if (is_write) begin
                    state <= WDATA;
                  end else begin
                    out_rd_strobe <= 1'b1;
                    state         <= RDATA;
                  end
                end
              end
              WDATA: begin
                data_sh <= data_next;
                if (cnt == LAST_WR_CNT) begin
                  out_wr_data   <= data_next;
                  out_wr_strobe <= 1'b1;
                  state         <= DONE;
                end
              end
              RDATA: begin
                if (cnt == RD_LOAD_CNT) begin
                  data_sh <= in_rd_data;
                  oe      <= 1'b1;
                end else if (cnt == RD_END_CNT) begin
                  oe    <= 1'b0;
                  state <= DONE;
                end else begin
                  data_sh <= {data_sh[DATA_BITS-2:0], 1'b0};
                end
              end
              default: state <= IDLE;
            endcase
          end
        end

        DONE: begin
          oe <= 1'b0;
          if (cs_s2) state <= IDLE;
        end

        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule

`default_nettype wire
